// File: rtl/lb_baud_pkg.sv
// ============================================================================
// Module  : lb_baud_pkg
// Brief   : Shared widths and oversample-factor constants for the baud tick generator.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package lb_baud_pkg;

   localparam int PRESCALE_W_DEF = 20;
   localparam int OVS_W_DEF      = 4;

   // The ovs field holds the oversample factor minus one.
   localparam int OVS_16X = 15;
   localparam int OVS_8X  = 7;
   localparam int OVS_1X  = 0;

endpackage : lb_baud_pkg

`default_nettype wire

// File: rtl/lb_reload_down_counter.sv
// ============================================================================
// Module  : lb_reload_down_counter
// Brief   : Down counter that reloads on restart or on reaching zero while enabled.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module lb_reload_down_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   input  logic             i_restart,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_restart) begin
         r_cnt <= i_load_val;
      end else if (i_en) begin
         if (r_cnt == '0) begin
            r_cnt <= i_load_val;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign o_tc = (r_cnt == '0);

endmodule : lb_reload_down_counter

`default_nettype wire

// File: rtl/lb_baud_tick_gen.sv
// ============================================================================
// Module  : lb_baud_tick_gen
// Brief   : Prescaled oversample tick generator with mid-bit and end-of-bit ticks.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module lb_baud_tick_gen
   import lb_baud_pkg::*;
#(
   parameter int PRESCALE_W = PRESCALE_W_DEF,
   parameter int OVS_W      = OVS_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs,
   input  logic                  load,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [OVS_W-1:0]      ovs,
   input  logic                  sync_start,
   output logic                  sample_tick,
   output logic                  half_tick,
   output logic                  bit_tick
);

   logic [PRESCALE_W-1:0] r_pre;
   logic [OVS_W-1:0]      r_ovs;
   logic [OVS_W-1:0]      r_ovs_cnt;
   logic                  r_sample_tick;
   logic                  r_half_tick;
   logic                  r_bit_tick;

   logic [PRESCALE_W-1:0] w_reload_val;
   logic                  w_restart;
   logic                  w_pre_tc;
   logic [OVS_W-1:0]      w_half_pt;
   logic                  w_half_hit;
   logic                  w_bit_hit;

   // On load the new prescale must reach the counter in the same cycle as the shadow.
   assign w_reload_val = load ? prescale : r_pre;
   assign w_restart    = load | sync_start;

   lb_reload_down_counter #(
      .WIDTH (PRESCALE_W)
   ) u_pre (
      .clk        (clk),
      .reset      (reset),
      .i_load_val (w_reload_val),
      .i_en       (cs),
      .i_restart  (w_restart),
      .o_tc       (w_pre_tc)
   );

   assign w_half_pt  = r_ovs >> 1;
   assign w_half_hit = (r_ovs_cnt == w_half_pt);
   assign w_bit_hit  = (r_ovs_cnt == r_ovs);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pre         <= '0;
         r_ovs         <= '0;
         r_ovs_cnt     <= '0;
         r_sample_tick <= 1'b0;
         r_half_tick   <= 1'b0;
         r_bit_tick    <= 1'b0;
      end else if (load) begin
         r_pre         <= prescale;
         r_ovs         <= ovs;
         r_ovs_cnt     <= '0;
         r_sample_tick <= 1'b0;
         r_half_tick   <= 1'b0;
         r_bit_tick    <= 1'b0;
      end else if (sync_start) begin
         r_ovs_cnt     <= '0;
         r_sample_tick <= 1'b0;
         r_half_tick   <= 1'b0;
         r_bit_tick    <= 1'b0;
      end else if (cs) begin
         r_sample_tick <= w_pre_tc;
         r_half_tick   <= w_pre_tc & w_half_hit;
         r_bit_tick    <= w_pre_tc & w_bit_hit;
         if (w_pre_tc) begin
            r_ovs_cnt <= w_bit_hit ? '0 : r_ovs_cnt + 1'b1;
         end
      end else begin
         r_sample_tick <= 1'b0;
         r_half_tick   <= 1'b0;
         r_bit_tick    <= 1'b0;
      end
   end

   assign sample_tick = r_sample_tick;
   assign half_tick   = r_half_tick;
   assign bit_tick    = r_bit_tick;

endmodule : lb_baud_tick_gen

`default_nettype wire
